glitc_clock_delay_scanner: RTL and testbench
============================================

# glitc_clock_delay_scanner

Calibration controller that sits directly upstream of the GLITC clock-path wrapper and drives its IDELAY tap value and load flag in the `clk_i` domain. It sweeps all 32 N-path IDELAY taps and majority-samples the registered N-path output at each tap to find the clock edge. It then loads the edge tap plus a programmable offset as the operating delay. A manual load path lets software write a tap directly.

## Interface
Parameters:
- `SETTLE_CYCLES`, 16: wait after each load before sampling; covers the flag crossing into SYSCLK_DIV2_PS, the IDELAY update and input synchronization; legal 4..255.
- `SAMPLE_COUNT`, 64: samples accumulated per tap; legal 1..1024.
- `OFFSET`, 8: tap offset added to the detected edge; legal 0..31.

Ports (one clock; reset is asynchronous and active-low):
- `clk_i` in 1: system clock; all logic on its rising edge.
- `rst_n_i` in 1: asynchronous, active-low reset.
- `start_i` in 1: single-cycle scan request.
- `manual_delay_i` in 5: manual tap value.
- `manual_load_i` in 1: single-cycle manual load request.
- `n_q_i` in 1: N-path registered sample from the clock-path wrapper; treated as asynchronous.
- `delay_o` out 5: tap value to the wrapper's `delay_clk_i`.
- `load_o` out 1: single-cycle load flag to the wrapper's `load_clk_i`.
- `busy_o` out 1: scan or manual load in progress.
- `done_o` out 1: scan complete; held until the next accepted `start_i` or manual load.
- `edge_found_o` out 1: the last scan found a transition.
- `edge_tap_o` out 5: the first tap whose classification differs from the previous tap.
- `history_o` out 32: per-tap classification bitmap; see Configuration.

## Operation
- Reset values: every output is 0. Internal tap counter is 0 and the FSM is in IDLE.
- `n_q_i` passes through a 2-flop synchronizer before any use.
- FSM states: IDLE, SET, LOAD, SETTLE, SAMPLE, EVAL, FSET, FLOAD, FSETTLE, DONE, MSET, MLOAD.
- IDLE / DONE transitions:
  - `start_i` → SET. Clears tap, `done_o`, `edge_found_o`, `edge_tap_o` and history.
  - Else `manual_load_i` → MSET.
  - `start_i` wins if both requests are asserted together.
- Scan loop, per tap:
  - SET: `delay_o`←tap.
  - LOAD: `load_o`=1.
  - SETTLE: `SETTLE_CYCLES` cycles.
  - SAMPLE: `SAMPLE_COUNT` cycles, counting synchronized ones into a counter of width clog2(`SAMPLE_COUNT`+1).
  - EVAL: the tap is classified high iff 2·ones > `SAMPLE_COUNT`; a tie classifies low. If tap>0, `edge_found_o` is 0, and the class differs from the previous tap, then `edge_found_o`←1 and `edge_tap_o`←tap. History bit [tap] is set to the class.
  - EVAL at tap 31 → FSET; otherwise tap+1 and → SET.
- Final load:
  - FSET: `delay_o`←(`edge_tap_o`+`OFFSET`) mod 32. The 5-bit add wraps, and `edge_tap_o`=0 when no edge was found.
  - FLOAD: `load_o`=1.
  - FSETTLE: `SETTLE_CYCLES` cycles.
  - → DONE with `done_o`=1.
- Manual load: MSET sets `delay_o`←`manual_delay_i` and clears `done_o`; MLOAD sets `load_o`=1; then → IDLE.
- `busy_o`=1 in every state except IDLE and DONE. `start_i` and `manual_load_i` are ignored while busy.
- Reset mid-operation immediately returns all outputs to reset values. The downstream IDELAY retains its last loaded tap, so software must rescan.

## Timing
- `delay_o` changes exactly one cycle before `load_o` rises and is held until the next SET/FSET/MSET.
- `load_o` pulses are always one cycle long and are separated by at least `SETTLE_CYCLES`+`SAMPLE_COUNT`+2 cycles during a scan.
- Per-tap cost is `SETTLE_CYCLES`+`SAMPLE_COUNT`+3 cycles.
- With `start_i` sampled at cycle 0, `done_o` rises at cycle 32·(S+N+3)+S+3, where S=`SETTLE_CYCLES` and N=`SAMPLE_COUNT`.
- Manual load: `delay_o` updates at cycle 1 and `load_o` pulses at cycle 2 after `manual_load_i`.
- `edge_*` and `history_o` are valid whenever `done_o`=1.

## Configuration
- `GLITC_CLKSCAN_HISTORY_EN` defined: a 32-bit history register is built and `history_o` reflects it. Bit n=1 means tap n was classified high.
- `GLITC_CLKSCAN_HISTORY_EN` undefined: no history register is built and `history_o` is tied to 0. All other behaviour is identical.

## Test plan
Bench parameters: `SETTLE_CYCLES`=4, `SAMPLE_COUNT`=8, `OFFSET`=8, history enabled. The N-path model outputs 1 when the tap latched at `load_o` is ≥ a threshold T.
- T=12, start → `edge_found_o`=1, `edge_tap_o`=12, final `delay_o`=20, `history_o`=0xFFFFF000, `done_o` at cycle 487.
- T=28 → `edge_tap_o`=28, final `delay_o`=4 (wrap).
- `n_q_i` constantly 1 → `edge_found_o`=0, `history_o`=0xFFFFFFFF, final `delay_o`=8.
- Tap 5 model emits exactly 4 of 8 ones → classified low; emits 5 of 8 → classified high, so `edge_tap_o`=5 when lower taps are low.
- Reset asserted during tap 10 → all outputs 0 immediately; a new start sweeps from tap 0 with the first `load_o` carrying `delay_o`=0.
- Idle, `manual_load_i` with 0x13 → `delay_o`=19 at +1 and `load_o` pulse at +2; `start_i` and `manual_load_i` during a scan are ignored, with no change to `load_o` spacing.

Source files
------------

// File: rtl/glitc_clock_delay_scanner_if.sv
// Bundle of request, sample and result signals between the GLITC clock-delay
// scanner (slave side) and whatever drives it and the clock-path wrapper.
interface glitc_clock_delay_scanner_if;
   logic        start_i;
   logic [4:0]  manual_delay_i;
   logic        manual_load_i;
   logic        n_q_i;
   logic [4:0]  delay_o;
   logic        load_o;
   logic        busy_o;
   logic        done_o;
   logic        edge_found_o;
   logic [4:0]  edge_tap_o;
   logic [31:0] history_o;

   modport slave (
      input  start_i, manual_delay_i, manual_load_i, n_q_i,
      output delay_o, load_o, busy_o, done_o, edge_found_o, edge_tap_o, history_o
   );

   modport master (
      output start_i, manual_delay_i, manual_load_i, n_q_i,
      input  delay_o, load_o, busy_o, done_o, edge_found_o, edge_tap_o, history_o
   );
endinterface

// File: rtl/glitc_clock_delay_scanner.sv
// Sweeps the 32 IDELAY taps, majority-samples the N-path to find the clock edge and
// loads edge+OFFSET. Define GLITC_CLKSCAN_HISTORY_EN to build the per-tap history bitmap.
module glitc_clock_delay_scanner #(
   parameter int SETTLE_CYCLES = 16,
   parameter int SAMPLE_COUNT  = 64,
   parameter int OFFSET        = 8
) (
   input  logic                          clk_i,
   input  logic                          rst_n_i,
   glitc_clock_delay_scanner_if.slave    bus
);

   localparam int ONES_W = $clog2(SAMPLE_COUNT + 1);

   typedef enum logic [3:0] {
      IDLE, SET, LOAD, SETTLE, SAMPLE, EVAL,
      FSET, FLOAD, FSETTLE, DONE, MSET, MLOAD
   } state_t;

   state_t              r_state;
   state_t              w_state_next;
   logic [9:0]          r_cnt;
   logic [1:0]          r_sync;
   logic [ONES_W-1:0]   r_ones;
   logic [4:0]          r_tap;
   logic [4:0]          r_delay;
   logic                r_load;
   logic                r_busy;
   logic                r_done;
   logic                r_edge_found;
   logic [4:0]          r_edge_tap;
   logic                r_prev_class;

   logic                w_idle_like;
   logic                w_start_acc;
   logic                w_man_acc;
   logic [ONES_W:0]     w_ones_x2;
   logic                w_class;
   logic                w_edge_hit;
   logic [4:0]          w_edge_tap_eff;

   assign w_idle_like    = (r_state == IDLE) || (r_state == DONE);
   assign w_start_acc    = w_idle_like && bus.start_i;
   assign w_man_acc      = w_idle_like && !bus.start_i && bus.manual_load_i;
   // Strict majority: a tie classifies the tap as low.
   assign w_ones_x2      = {r_ones, 1'b0};
   assign w_class        = int'(w_ones_x2) > SAMPLE_COUNT;
   assign w_edge_hit     = (r_state == EVAL) && (r_tap != 5'd0) && !r_edge_found &&
                           (w_class != r_prev_class);
   // An edge found at tap 31 must already feed the final delay computed in the same cycle.
   assign w_edge_tap_eff = w_edge_hit ? r_tap : r_edge_tap;

   always_comb begin
      w_state_next = r_state;
      case (r_state)
         IDLE, DONE: begin
            if (bus.start_i)            w_state_next = SET;
            else if (bus.manual_load_i) w_state_next = MSET;
         end
         SET:     w_state_next = LOAD;
         LOAD:    w_state_next = SETTLE;
         SETTLE:  if (r_cnt == 10'(SETTLE_CYCLES - 1)) w_state_next = SAMPLE;
         SAMPLE:  if (r_cnt == 10'(SAMPLE_COUNT - 1))  w_state_next = EVAL;
         EVAL:    w_state_next = (r_tap == 5'd31) ? FSET : SET;
         FSET:    w_state_next = FLOAD;
         FLOAD:   w_state_next = FSETTLE;
         FSETTLE: if (r_cnt == 10'(SETTLE_CYCLES - 1)) w_state_next = DONE;
         MSET:    w_state_next = MLOAD;
         MLOAD:   w_state_next = IDLE;
         default: w_state_next = IDLE;
      endcase
   end

   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         r_state <= IDLE;
         r_cnt   <= '0;
         r_sync  <= '0;
         r_load  <= 1'b0;
         r_busy  <= 1'b0;
      end else begin
         r_state <= w_state_next;
         r_cnt   <= (w_state_next != r_state) ? 10'd0 : r_cnt + 10'd1;
         r_sync  <= {r_sync[0], bus.n_q_i};
         // Registered so load and busy are clean flop outputs into the wrapper.
         r_load  <= (w_state_next == LOAD) || (w_state_next == FLOAD) || (w_state_next == MLOAD);
         r_busy  <= (w_state_next != IDLE) && (w_state_next != DONE);
      end
   end

   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         r_ones       <= '0;
         r_tap        <= '0;
         r_delay      <= '0;
         r_done       <= 1'b0;
         r_edge_found <= 1'b0;
         r_edge_tap   <= '0;
         r_prev_class <= 1'b0;
      end else if (w_start_acc) begin
         r_tap        <= '0;
         r_delay      <= '0;
         r_done       <= 1'b0;
         r_edge_found <= 1'b0;
         r_edge_tap   <= '0;
      end else if (w_man_acc) begin
         r_delay <= bus.manual_delay_i;
         r_done  <= 1'b0;
      end else begin
         case (r_state)
            SET:    r_ones <= '0;
            SAMPLE: r_ones <= r_ones + ONES_W'(r_sync[1]);
            EVAL: begin
               r_prev_class <= w_class;
               if (w_edge_hit) begin
                  r_edge_found <= 1'b1;
                  r_edge_tap   <= r_tap;
               end
               if (r_tap != 5'd31) begin
                  r_tap   <= r_tap + 5'd1;
                  r_delay <= r_tap + 5'd1;
               end else begin
                  r_delay <= w_edge_tap_eff + 5'(OFFSET);
               end
            end
            FSETTLE: if (w_state_next == DONE) r_done <= 1'b1;
            default: ;
         endcase
      end
   end

`ifdef GLITC_CLKSCAN_HISTORY_EN
   logic [31:0] r_history;

   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i)                 r_history <= '0;
      else if (w_start_acc)         r_history <= '0;
      else if (r_state == EVAL)     r_history[r_tap] <= w_class;
   end

   assign bus.history_o = r_history;
`else
   assign bus.history_o = '0;
`endif

   assign bus.delay_o      = r_delay;
   assign bus.load_o       = r_load;
   assign bus.busy_o       = r_busy;
   assign bus.done_o       = r_done;
   assign bus.edge_found_o = r_edge_found;
   assign bus.edge_tap_o   = r_edge_tap;

endmodule

// File: tb/tb_glitc_clock_delay_scanner.sv
// Self-checking bench: a threshold N-path model feeds the scanner, a per-cycle
// timeline model checks outputs, and literal expectations pin each scan result.
module tb_glitc_clock_delay_scanner;

   localparam int S      = 4;
   localparam int N      = 8;
   localparam int OFF    = 8;
   localparam int P      = S + N + 3;
   localparam int DONE_K = 32 * P + S + 3;

   logic clk   = 1'b0;
   logic rst_n = 1'b0;

   glitc_clock_delay_scanner_if bus();

   glitc_clock_delay_scanner #(
      .SETTLE_CYCLES (S),
      .SAMPLE_COUNT  (N),
      .OFFSET        (OFF)
   ) dut (
      .clk_i   (clk),
      .rst_n_i (rst_n),
      .bus     (bus)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;
   int cyc    = 0;
   always @(posedge clk) cyc <= cyc + 1;

   // N-path model: output follows the tap latched on load_o.
   int         nq_mode = 0;
   int         thr     = 32;
   int         t5_k    = -1;
   logic [4:0] lat_tap = 5'd0;
   int         ld_age  = 0;
   logic       nq;

   always @(posedge clk) begin
      if (bus.load_o) begin
         lat_tap <= bus.delay_o;
         ld_age  <= 0;
      end else begin
         ld_age  <= ld_age + 1;
      end
   end

   // Sampled window after a load is ld_age 2..9 (2-flop synchronizer), so tap 5 gets exactly t5_k ones.
   always_comb begin
      if (nq_mode == 1)                    nq = 1'b1;
      else if (t5_k >= 0 && lat_tap == 5)  nq = (ld_age >= 2) && (ld_age < 2 + t5_k);
      else                                 nq = (int'(lat_tap) >= thr);
   end
   assign bus.n_q_i = nq;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // Scan-result model from the classification rules.
   int          tap_ones [32];
   logic        exp_found;
   logic [4:0]  exp_tap;
   logic [31:0] exp_hist;
   logic [4:0]  exp_final;

   function automatic logic [31:0] hist_visible(input logic [31:0] h);
`ifdef GLITC_CLKSCAN_HISTORY_EN
      return h;
`else
      return (h & 32'h0);
`endif
   endfunction

   function void build_model();
      logic cls, prev;
      for (int t = 0; t < 32; t++) begin
         if (nq_mode == 1)                tap_ones[t] = N;
         else if (t5_k >= 0 && t == 5)    tap_ones[t] = t5_k;
         else                             tap_ones[t] = (t >= thr) ? N : 0;
      end
      exp_found = 1'b0;
      exp_tap   = 5'd0;
      exp_hist  = 32'd0;
      prev      = 1'b0;
      for (int t = 0; t < 32; t++) begin
         cls         = (2 * tap_ones[t]) > N;
         exp_hist[t] = cls;
         if (t > 0 && !exp_found && cls != prev) begin
            exp_found = 1'b1;
            exp_tap   = 5'(t);
         end
         prev = cls;
      end
      exp_final = 5'((int'(exp_tap) + OFF) % 32);
   endfunction

   // Per-cycle timeline checker while a scan is active.
   logic scan_on   = 1'b0;
   int   start_cyc = 0;

   always @(negedge clk) begin
      int k;
      int edelay;
      bit eload, ebusy, edone;
      if (scan_on) begin
         k = cyc - start_cyc;
         if (k >= 1) begin
            if (k <= 32 * P) begin
               edelay = (k - 1) / P;
               eload  = ((k - 1) % P) == 1;
               ebusy  = 1'b1;
               edone  = 1'b0;
            end else if (k < DONE_K) begin
               edelay = int'(exp_final);
               eload  = (k == 32 * P + 2);
               ebusy  = 1'b1;
               edone  = 1'b0;
            end else begin
               edelay = int'(exp_final);
               eload  = 1'b0;
               ebusy  = 1'b0;
               edone  = 1'b1;
            end
            check("tl_delay", 32'(bus.delay_o), 32'(edelay));
            check("tl_load",  32'(bus.load_o),  32'(eload));
            check("tl_busy",  32'(bus.busy_o),  32'(ebusy));
            check("tl_done",  32'(bus.done_o),  32'(edone));
            if (k == 1) begin
               check("tl_clr_found", 32'(bus.edge_found_o), 32'd0);
               check("tl_clr_tap",   32'(bus.edge_tap_o),   32'd0);
               check("tl_clr_hist",  bus.history_o,         32'd0);
            end
            if (k >= DONE_K) begin
               check("tl_found", 32'(bus.edge_found_o), 32'(exp_found));
               check("tl_tap",   32'(bus.edge_tap_o),   32'(exp_tap));
               check("tl_hist",  bus.history_o,         hist_visible(exp_hist));
            end
         end
      end
   end

   task automatic check_all_zero(input string tag);
      check({tag, "_delay"}, 32'(bus.delay_o),      32'd0);
      check({tag, "_load"},  32'(bus.load_o),       32'd0);
      check({tag, "_busy"},  32'(bus.busy_o),       32'd0);
      check({tag, "_done"},  32'(bus.done_o),       32'd0);
      check({tag, "_found"}, 32'(bus.edge_found_o), 32'd0);
      check({tag, "_tap"},   32'(bus.edge_tap_o),   32'd0);
      check({tag, "_hist"},  bus.history_o,         32'd0);
   endtask

   task automatic begin_scan(input int mode, input int t, input int k5, input bit both);
      nq_mode = mode;
      thr     = t;
      t5_k    = k5;
      build_model();
      @(negedge clk);
      bus.start_i        = 1'b1;
      bus.manual_load_i  = both;
      bus.manual_delay_i = 5'h1F;
      start_cyc          = cyc;
      scan_on            = 1'b1;
      @(negedge clk);
      bus.start_i       = 1'b0;
      bus.manual_load_i = 1'b0;
   endtask

   task automatic run_scan(input int mode, input int t, input int k5, input bit both, input bit inject);
      bit got;
      got = 1'b0;
      begin_scan(mode, t, k5, both);
      for (int i = 0; i < DONE_K + 20; i++) begin
         @(negedge clk);
         bus.start_i       = inject && (cyc - start_cyc == 100);
         bus.manual_load_i = inject && (cyc - start_cyc == 200);
         if (bus.done_o) begin
            got = 1'b1;
            break;
         end
      end
      bus.start_i       = 1'b0;
      bus.manual_load_i = 1'b0;
      check("done_seen",  32'(got), 32'd1);
      check("done_cycle", 32'(cyc - start_cyc), 32'(DONE_K));
      repeat (2) @(negedge clk);
      scan_on = 1'b0;
   endtask

   task automatic lit(input string tag, input logic found, input logic [4:0] tap,
                      input logic [4:0] fin, input logic [31:0] hist);
      check({tag, "_found"}, 32'(bus.edge_found_o), 32'(found));
      check({tag, "_tap"},   32'(bus.edge_tap_o),   32'(tap));
      check({tag, "_final"}, 32'(bus.delay_o),      32'(fin));
      check({tag, "_hist"},  bus.history_o,         hist_visible(hist));
   endtask

   initial begin
      bus.start_i        = 1'b0;
      bus.manual_load_i  = 1'b0;
      bus.manual_delay_i = 5'd0;

      repeat (3) @(negedge clk);
      check_all_zero("rst_hold");
      rst_n = 1'b1;
      @(negedge clk);
      check_all_zero("rst_idle");

      // T=12 with ignored requests at k=100 and k=200.
      run_scan(0, 12, -1, 1'b0, 1'b1);
      lit("t12", 1'b1, 5'd12, 5'd20, 32'hFFFFF000);

      // Manual load from DONE: delay at +1, load at +2, done cleared.
      @(negedge clk);
      bus.manual_load_i  = 1'b1;
      bus.manual_delay_i = 5'h13;
      @(negedge clk);
      bus.manual_load_i  = 1'b0;
      bus.manual_delay_i = 5'h00;
      check("man1_delay", 32'(bus.delay_o), 32'd19);
      check("man1_load",  32'(bus.load_o),  32'd0);
      check("man1_busy",  32'(bus.busy_o),  32'd1);
      check("man1_done",  32'(bus.done_o),  32'd0);
      @(negedge clk);
      check("man2_delay", 32'(bus.delay_o), 32'd19);
      check("man2_load",  32'(bus.load_o),  32'd1);
      @(negedge clk);
      check("man3_load",  32'(bus.load_o),  32'd0);
      check("man3_busy",  32'(bus.busy_o),  32'd0);
      check("man3_delay", 32'(bus.delay_o), 32'd19);

      // T=28 with manual_load asserted alongside start (start wins).
      run_scan(0, 28, -1, 1'b1, 1'b0);
      lit("t28", 1'b1, 5'd28, 5'd4, 32'hF0000000);

      run_scan(1, 0, -1, 1'b0, 1'b0);
      lit("const1", 1'b0, 5'd0, 5'd8, 32'hFFFFFFFF);

      run_scan(0, 6, 4, 1'b0, 1'b0);
      lit("tie4", 1'b1, 5'd6, 5'd14, 32'hFFFFFFC0);

      run_scan(0, 6, 5, 1'b0, 1'b0);
      lit("maj5", 1'b1, 5'd5, 5'd13, 32'hFFFFFFE0);

      // Reset during tap 10, then a fresh sweep from tap 0.
      begin_scan(0, 12, -1, 1'b0);
      for (int i = 0; i < 10 * P + 20; i++) begin
         @(negedge clk);
         if (cyc - start_cyc >= 10 * P + 5) break;
      end
      check("pre_rst_delay", 32'(bus.delay_o), 32'd10);
      scan_on = 1'b0;
      #2 rst_n = 1'b0;
      #1 check_all_zero("midrst");
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      check_all_zero("post_rst");
      run_scan(0, 12, -1, 1'b0, 1'b0);
      lit("rescan", 1'b1, 5'd12, 5'd20, 32'hFFFFF000);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
